// File: rtl/row_sequencer.sv
`default_nettype none
// ============================================================================
// row_sequencer : issues one begin_mult per row, keeps the running argmax over
//                 the returned row results, and runs a watchdog on each row.
// Revision      : 1.0 - initial release
// ============================================================================
module row_sequencer #(
  parameter int NUM_ROWS       = 10,
  parameter int RESULT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  output logic                    begin_mult,
  output logic [3:0]              row_select,
  input  logic                    done_row,
  input  logic [RESULT_WIDTH-1:0] row_result,
  input  logic                    overflow,
  output logic                    busy,
  output logic                    classify_done,
  output logic [3:0]              digit,
  output logic [RESULT_WIDTH-1:0] max_value,
  output logic                    any_overflow,
  output logic                    timeout
);

  localparam logic [3:0]  LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [10:0] WD_LIMIT = 11'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              row_q, row_d;
  logic [10:0]             wd_q, wd_d;
  logic [3:0]              digit_q, digit_d;
  logic [RESULT_WIDTH-1:0] max_q, max_d;
  logic                    anyovf_q, anyovf_d;
  logic                    timeout_q, timeout_d;
  logic [RESULT_WIDTH-1:0] eff_value;

  // A saturated row counts as the largest possible value.
  assign eff_value = overflow ? {RESULT_WIDTH{1'b1}} : row_result;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      row_q     <= 4'd0;
      wd_q      <= 11'd0;
      digit_q   <= 4'd0;
      max_q     <= '0;
      anyovf_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      wd_q      <= wd_d;
      digit_q   <= digit_d;
      max_q     <= max_d;
      anyovf_q  <= anyovf_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    wd_d      = wd_q;
    digit_d   = digit_q;
    max_d     = max_q;
    anyovf_d  = anyovf_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          row_d     = 4'd0;
          digit_d   = 4'd0;
          max_d     = '0;
          anyovf_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wd_d    = 11'd0;
      end
      S_WAIT: begin
        if (done_row) begin
          // Strict compare keeps the lowest index on ties.
          if (row_q == 4'd0 || eff_value > max_q) begin
            digit_d = row_q;
            max_d   = eff_value;
          end
          if (overflow) anyovf_d = 1'b1;
          if (row_q < LAST_ROW) begin
            row_d   = row_q + 4'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wd_d = wd_q + 11'd1;
          if (wd_q + 11'd1 == WD_LIMIT) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign begin_mult    = (state_q == S_ISSUE);
  assign classify_done = (state_q == S_DONE);
  assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign row_select    = row_q;
  assign digit         = digit_q;
  assign max_value     = max_q;
  assign any_overflow  = anyovf_q;
  assign timeout       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_row_sequencer.sv
`default_nettype none
// Bench for row_sequencer: acts as the multiplier, answers each begin_mult
// after a chosen latency and compares against an argmax reference model.
module tb_row_sequencer;
  localparam int NR = 10;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        begin_mult;
  logic [3:0]  row_select;
  logic        done_row;
  logic [15:0] row_result;
  logic        overflow;
  logic        busy;
  logic        classify_done;
  logic [3:0]  digit;
  logic [15:0] max_value;
  logic        any_overflow;
  logic        timeout;

  row_sequencer #(
    .NUM_ROWS      (10),
    .RESULT_WIDTH  (16),
    .TIMEOUT_CYCLES(1023)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .begin_mult   (begin_mult),
    .row_select   (row_select),
    .done_row     (done_row),
    .row_result   (row_result),
    .overflow     (overflow),
    .busy         (busy),
    .classify_done(classify_done),
    .digit        (digit),
    .max_value    (max_value),
    .any_overflow (any_overflow),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int bm_count = 0;
  int cd_count = 0;

  logic [15:0] res_a [NR];
  logic        ovf_a [NR];

  always @(posedge clk) begin
    if (begin_mult)    bm_count++;
    if (classify_done) cd_count++;
  end

  function automatic bit outputs_zero();
    return (begin_mult === 1'b0) && (row_select === 4'd0) && (busy === 1'b0) &&
           (classify_done === 1'b0) && (digit === 4'd0) && (max_value === 16'd0) &&
           (any_overflow === 1'b0) && (timeout === 1'b0);
  endfunction

  // Winner = largest effective value; among equals, the first row holding it.
  task automatic model(output logic [3:0] d, output logic [15:0] m, output bit a);
    logic [15:0] eff [NR];
    m = 16'd0;
    a = 1'b0;
    d = 4'd0;
    for (int r = 0; r < NR; r++) begin
      eff[r] = ovf_a[r] ? 16'hFFFF : res_a[r];
      if (eff[r] > m) m = eff[r];
      a = a | ovf_a[r];
    end
    for (int r = NR - 1; r >= 0; r--)
      if (eff[r] == m) d = 4'(r);
  endtask

  task automatic run_rows(input int lat, input bit stray, input int abort_row);
    int          bm0, cd0;
    logic [3:0]  exp_d;
    logic [15:0] exp_m;
    bit          exp_a;
    bit          stable;
    bm0 = bm_count;
    cd0 = cd_count;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (digit !== 4'd0 || max_value !== 16'd0 || any_overflow !== 1'b0 ||
        timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clear: digit=%0d max=%0d anyo=%b timeout=%b busy=%b, required 0 0 0 0 1",
               digit, max_value, any_overflow, timeout, busy);
    end
    for (int r = 0; r < NR; r++) begin
      n_checks++;
      if (begin_mult !== 1'b1 || row_select !== 4'(r)) begin
        n_fail++;
        $display("FAIL issue_row%0d: begin_mult=%b row_select=%0d, required 1 %0d",
                 r, begin_mult, row_select, r);
      end
      if (stray) begin
        done_row = 1'b1; row_result = 16'hFFFF; overflow = 1'b1;
      end
      stable = 1'b1;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        done_row = 1'b0;
        overflow = 1'b0;
        start    = stray && (i == 0);
        if (begin_mult !== 1'b0 || row_select !== 4'(r) || busy !== 1'b1) stable = 1'b0;
        if (r == abort_row && i == 2) begin
          start = 1'b0;
          return;
        end
      end
      start = 1'b0;
      n_checks++;
      if (!stable) begin
        n_fail++;
        $display("FAIL hold_row%0d: row_select/begin_mult/busy changed while waiting, required stable %0d 0 1",
                 r, r);
      end
      done_row = 1'b1; row_result = res_a[r]; overflow = ovf_a[r];
      @(negedge clk);
      done_row = 1'b0; overflow = 1'b0; row_result = 16'($urandom);
    end
    model(exp_d, exp_m, exp_a);
    n_checks++;
    if (classify_done !== 1'b1 || busy !== 1'b0 || begin_mult !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: classify_done=%b busy=%b begin_mult=%b, required 1 0 0",
               classify_done, busy, begin_mult);
    end
    n_checks++;
    if (digit !== exp_d || max_value !== exp_m || any_overflow !== exp_a) begin
      n_fail++;
      $display("FAIL result: digit=%0d max=%0d anyo=%b, required %0d %0d %b",
               digit, max_value, any_overflow, exp_d, exp_m, exp_a);
    end
    @(negedge clk);
    n_checks++;
    if (classify_done !== 1'b0 || bm_count - bm0 != NR || cd_count - cd0 != 1) begin
      n_fail++;
      $display("FAIL pulse_counts: classify_done=%b begin_mult_pulses=%0d done_pulses=%0d, required 0 %0d 1",
               classify_done, bm_count - bm0, cd_count - cd0, NR);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; done_row = 1'b0; row_result = 16'd0; overflow = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (!outputs_zero()) begin
      n_fail++;
      $display("FAIL reset_state: bm=%b row=%0d busy=%b cd=%b digit=%0d max=%0d anyo=%b to=%b, required all 0",
               begin_mult, row_select, busy, classify_done, digit, max_value, any_overflow, timeout);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ascending();
    for (int r = 0; r < NR; r++) begin res_a[r] = 16'(100 * r); ovf_a[r] = 1'b0; end
    run_rows(400, 1'b0, -1);
  endtask

  task automatic test_ties();
    for (int r = 0; r < NR; r++) begin res_a[r] = 16'd784; ovf_a[r] = 1'b0; end
    run_rows(5, 1'b0, -1);
  endtask

  task automatic test_overflow();
    for (int r = 0; r < NR; r++) begin res_a[r] = 16'd50; ovf_a[r] = 1'b0; end
    res_a[3] = 16'd5; ovf_a[3] = 1'b1;
    run_rows(4, 1'b0, -1);
  endtask

  task automatic test_timeout();
    int bm0, cd0;
    bm0 = bm_count;
    cd0 = cd_count;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (begin_mult !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_issue: begin_mult=%b, required 1", begin_mult);
    end
    repeat (1023) @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: timeout=%b busy=%b, required 0 1", timeout, busy);
    end
    @(negedge clk);
    n_checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || begin_mult !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: timeout=%b busy=%b begin_mult=%b, required 1 0 0",
               timeout, busy, begin_mult);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (timeout !== 1'b1 || bm_count - bm0 != 1 || cd_count - cd0 != 0) begin
      n_fail++;
      $display("FAIL timeout_sticky: timeout=%b begin_mult_pulses=%0d done_pulses=%0d, required 1 1 0",
               timeout, bm_count - bm0, cd_count - cd0);
    end
    for (int r = 0; r < NR; r++) begin res_a[r] = 16'($urandom); ovf_a[r] = 1'b0; end
    run_rows(3, 1'b0, -1);
  endtask

  task automatic test_reset_midrun();
    int bm0;
    for (int r = 0; r < NR; r++) begin res_a[r] = 16'(100 * r); ovf_a[r] = 1'b0; end
    run_rows(4, 1'b0, 5);
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if (!outputs_zero()) begin
      n_fail++;
      $display("FAIL async_reset: bm=%b row=%0d busy=%b digit=%0d max=%0d, required all 0",
               begin_mult, row_select, busy, digit, max_value);
    end
    @(negedge clk); n_rst = 1'b1;
    bm0 = bm_count;
    repeat (20) @(negedge clk);
    n_checks++;
    if (bm_count != bm0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: begin_mult_pulses=%0d busy=%b, required 0 0", bm_count - bm0, busy);
    end
    for (int r = 0; r < NR; r++) begin
      res_a[r] = 16'($urandom_range(0, 2000)); ovf_a[r] = 1'b0;
    end
    run_rows(2, 1'b0, -1);
  endtask

  task automatic test_ignored();
    int          bm0;
    logic [3:0]  d0;
    logic [15:0] m0;
    logic        a0;
    for (int r = 0; r < NR; r++) begin res_a[r] = 16'(100 * r); ovf_a[r] = 1'b0; end
    run_rows(3, 1'b1, -1);
    d0 = digit; m0 = max_value; a0 = any_overflow;
    bm0 = bm_count;
    @(negedge clk);
    done_row = 1'b1; row_result = 16'hFFFF; overflow = 1'b1;
    repeat (2) @(negedge clk);
    done_row = 1'b0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (digit !== d0 || max_value !== m0 || any_overflow !== a0 || bm_count != bm0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done_ignored: digit=%0d max=%0d anyo=%b pulses=%0d busy=%b, required %0d %0d %b 0 0",
               digit, max_value, any_overflow, bm_count - bm0, busy, d0, m0, a0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < NR; r++) begin
        res_a[r] = (k % 2 == 0) ? 16'($urandom_range(0, 7) * 100) : 16'($urandom);
        ovf_a[r] = ($urandom_range(0, 7) == 0);
      end
      run_rows(int'($urandom_range(1, 30)), 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_ties();
    test_overflow();
    test_timeout();
    test_reset_midrun();
    test_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
